// File: rtl/sort_mem_responder.sv
// Memory-side responder for the sort engine: AXI-lite-style AR/R and AW/W/B
// channels over a small word array, with a handshake-free preload port.
module sort_mem_responder #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int MEM_SIZE  = 16,
  parameter int READ_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_addr,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_addr,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp,
  input  logic                 init_we,
  input  logic [ADDR_WDTH-1:0] init_addr,
  input  logic [DATA_WDTH-1:0] init_data
);

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_t;

  r_state_t r_state, r_state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic r_load;

  logic [ADDR_WDTH-1:0] r_addr;
  logic [ADDR_WDTH-1:0] aw_addr_q;
  logic [DATA_WDTH-1:0] w_data_q;
  logic [DATA_WDTH-1:0] mem [MEM_SIZE];

  logic ar_fire, r_fire, aw_fire, w_fire, b_fire, commit;
  logic r_in_range, w_in_range, i_in_range;

  assign ar_fire = ar_valid && ar_ready;
  assign r_fire  = r_valid && r_ready;
  assign aw_fire = aw_valid && aw_ready;
  assign w_fire  = w_valid && w_ready;
  assign b_fire  = b_valid && b_ready;
  assign commit  = !aw_ready && !w_ready && !b_valid;

  assign r_in_range = 32'(r_addr) < 32'(MEM_SIZE);
  assign w_in_range = 32'(aw_addr_q) < 32'(MEM_SIZE);
  assign i_in_range = 32'(init_addr) < 32'(MEM_SIZE);

  // Every read passes through R_WAIT, so r_valid lands READ_WAIT+1 edges after AR.
  always_comb begin
    r_state_nxt  = r_state;
    wait_cnt_nxt = wait_cnt;
    r_load       = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_nxt  = R_WAIT;
          wait_cnt_nxt = 4'(READ_WAIT);
        end
      end
      R_WAIT: begin
        if (wait_cnt == 4'd0) begin
          r_state_nxt = R_RESP;
          r_load      = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      R_RESP: begin
        if (r_fire) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      wait_cnt <= '0;
      r_addr   <= '0;
      ar_ready <= 1'b1;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= '0;
    end else begin
      r_state  <= r_state_nxt;
      wait_cnt <= wait_cnt_nxt;
      ar_ready <= (r_state_nxt == R_IDLE);
      if (ar_fire) r_addr <= ar_addr;
      if (r_load) begin
        r_valid <= 1'b1;
        r_data  <= r_in_range ? mem[r_addr] : '0;
        r_resp  <= r_in_range ? '0 : RESP_WDTH'(1);
      end else if (r_fire) begin
        r_valid <= 1'b0;
      end
    end
  end

  // aw_ready/w_ready low doubles as "captured and held" for each channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_ready  <= 1'b1;
      w_ready   <= 1'b1;
      b_valid   <= 1'b0;
      b_resp    <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      if (aw_fire) begin
        aw_addr_q <= aw_addr;
        aw_ready  <= 1'b0;
      end
      if (w_fire) begin
        w_data_q <= w_data;
        w_ready  <= 1'b0;
      end
      if (commit) begin
        b_valid <= 1'b1;
        b_resp  <= w_in_range ? '0 : RESP_WDTH'(1);
      end
      if (b_fire) begin
        b_valid  <= 1'b0;
        aw_ready <= 1'b1;
        w_ready  <= 1'b1;
      end
    end
  end

  // Preload is assigned last so it overrides a same-address commit.
  always_ff @(posedge clk) begin
    if (commit && w_in_range) mem[aw_addr_q] <= w_data_q;
    if (init_we && i_in_range) mem[init_addr] <= init_data;
  end

endmodule

// File: tb/tb_sort_mem_responder.sv
// Scoreboard bench for sort_mem_responder (MEM_SIZE=10, READ_WAIT=1).
// Expected responses are queued at stimulus time and popped on R/B valid.
`timescale 1ns/1ps
module tb_sort_mem_responder;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ar_valid = 1'b0, ar_ready;
  logic [AW-1:0] ar_addr = '0;
  logic r_valid, r_ready = 1'b0;
  logic [DW-1:0] r_data;
  logic [0:0] r_resp;
  logic aw_valid = 1'b0, aw_ready;
  logic [AW-1:0] aw_addr = '0;
  logic w_valid = 1'b0, w_ready;
  logic [DW-1:0] w_data = '0;
  logic b_valid, b_ready = 1'b0;
  logic [0:0] b_resp;
  logic init_we = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [DW-1:0] init_data = '0;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model [MS];
  logic [DW:0] r_q [$];
  logic [0:0] b_q [$];

  always #5 clk = ~clk;

  sort_mem_responder #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(1),
    .MEM_SIZE(MS), .READ_WAIT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  function automatic logic [DW:0] exp_read(input logic [AW-1:0] a);
    if (int'(a) < MS) return {1'b0, model[a]};
    return {1'b1, {DW{1'b0}}};
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
    if (int'(a) < MS) model[a] = d;
  endtask

  // Issues AR and waits for r_valid; leaves the response pending.
  task automatic do_read(input logic [AW-1:0] a, output int lat,
                         output bit rdy_seen);
    @(negedge clk);
    r_q.push_back(exp_read(a));
    ar_valid = 1'b1; ar_addr = a;
    @(negedge clk);
    ar_valid = 1'b0;
    lat = 0;
    rdy_seen = ar_ready;
    while (!r_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ar_ready && !r_valid) rdy_seen = 1'b1;
    end
  endtask

  task automatic finish_read();
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int order, output int lat);
    @(negedge clk);
    b_q.push_back((int'(a) < MS) ? 1'b0 : 1'b1);
    if (int'(a) < MS) model[a] = d;
    if (order != 2) begin w_valid = 1'b1; w_data = d; end
    if (order != 1) begin aw_valid = 1'b1; aw_addr = a; end
    @(negedge clk);
    if (order == 1) begin w_valid = 1'b0; aw_valid = 1'b1; aw_addr = a; end
    if (order == 2) begin aw_valid = 1'b0; w_valid = 1'b1; w_data = d; end
    if (order != 0) @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    lat = 0;
    while (!b_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_write();
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic check_r(input string name);
    logic [DW:0] e;
    tests++;
    if (r_q.size() == 0) begin
      fails++;
      $display("FAIL %s: r response with empty scoreboard", name);
      return;
    end
    e = r_q.pop_front();
    if ({r_resp, r_data} !== e) begin
      fails++;
      $display("FAIL %s: got resp=%0d data=%h want resp=%0d data=%h",
               name, r_resp, r_data, e[DW], e[DW-1:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({ar_ready, aw_ready, w_ready, r_valid, b_valid} !== 5'b11100 ||
        r_data !== '0 || r_resp !== 1'b0 || b_resp !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%b%b%b rv=%b bv=%b rd=%h rr=%b br=%b",
               ar_ready, aw_ready, w_ready, r_valid, b_valid,
               r_data, r_resp, b_resp);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_latency();
    int lat; bit rs;
    for (int i = 0; i < MS; i++) preload(AW'(i), 32'h1000_0000 + 32'(i * 17));
    preload(4'd3, 32'hDEADBEEF);
    do_read(4'd3, lat, rs);
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL read_latency: got %0d want 2", lat);
    end
    tests++;
    if (rs) begin
      fails++; $display("FAIL ar_ready_busy: got 1 want 0 before R");
    end
    check_r("read_addr3");
    finish_read();
    tests++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
      fails++;
      $display("FAIL read_done: rv=%b ar_ready=%b want 0/1", r_valid, ar_ready);
    end
  endtask

  task automatic test_read_stall();
    int lat; bit rs;
    logic [DW-1:0] d0;
    do_read(4'd4, lat, rs);
    d0 = r_data;
    for (int i = 0; i < 5; i++) begin
      ar_valid = 1'b1; ar_addr = 4'd5;
      @(negedge clk);
      tests++;
      if (r_valid !== 1'b1 || r_data !== d0 || ar_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_%0d: rv=%b rd=%h ar_ready=%b want 1/%h/0",
                 i, r_valid, r_data, ar_ready, d0);
      end
    end
    ar_valid = 1'b0;
    check_r("stall_data");
    finish_read();
    tests++;
    if (r_valid !== 1'b0) begin
      fails++; $display("FAIL stall_extra: r_valid=%b want 0", r_valid);
    end
  endtask

  task automatic test_write_w_first();
    int lat; bit rs;
    do_write(4'd7, 32'h5, 1, lat);
    tests++;
    if (lat !== 1 || b_resp !== b_q.pop_front()) begin
      fails++; $display("FAIL write_wfirst: lat=%0d resp=%b want 1/0", lat, b_resp);
    end
    finish_write();
    tests++;
    if (aw_ready !== 1'b1 || w_ready !== 1'b1 || b_valid !== 1'b0) begin
      fails++;
      $display("FAIL write_done: aw=%b w=%b bv=%b want 1/1/0",
               aw_ready, w_ready, b_valid);
    end
    do_write(4'd1, 32'hA5A5_0001, 2, lat);
    tests++;
    if (lat !== 1 || b_resp !== b_q.pop_front()) begin
      fails++; $display("FAIL write_awfirst: lat=%0d resp=%b want 1/0", lat, b_resp);
    end
    finish_write();
    do_write(4'd0, 32'h0BAD_F00D, 0, lat);
    tests++;
    if (lat !== 1 || b_resp !== b_q.pop_front()) begin
      fails++; $display("FAIL write_same: lat=%0d resp=%b want 1/0", lat, b_resp);
    end
    finish_write();
    do_read(4'd7, lat, rs);
    check_r("readback_7");
    finish_read();
    do_read(4'd1, lat, rs);
    check_r("readback_1");
    finish_read();
  endtask

  task automatic test_errors();
    int lat; bit rs;
    do_read(4'd12, lat, rs);
    check_r("read_oob");
    finish_read();
    do_write(4'd12, 32'hFFFF_FFFF, 0, lat);
    tests++;
    if (b_resp !== b_q.pop_front()) begin
      fails++; $display("FAIL write_oob: resp=%b want 1", b_resp);
    end
    finish_write();
    for (int i = 0; i < MS; i++) begin
      do_read(AW'(i), lat, rs);
      check_r($sformatf("scan_%0d", i));
      finish_read();
    end
  endtask

  task automatic test_hazard();
    int lat; bit rs;
    logic [DW-1:0] old;
    old = model[2];
    @(negedge clk);
    r_q.push_back({1'b0, old});
    ar_valid = 1'b1; ar_addr = 4'd2;
    @(negedge clk);
    ar_valid = 1'b0;
    b_q.push_back(1'b0);
    aw_valid = 1'b1; aw_addr = 4'd2;
    w_valid = 1'b1; w_data = 32'h2222_BEEF;
    model[2] = 32'h2222_BEEF;
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (r_valid !== 1'b1 || b_valid !== 1'b1) begin
      fails++; $display("FAIL hazard_edge: rv=%b bv=%b want 1/1", r_valid, b_valid);
    end
    check_r("hazard_old");
    tests++;
    if (b_resp !== b_q.pop_front()) begin
      fails++; $display("FAIL hazard_b: resp=%b want 0", b_resp);
    end
    r_ready = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0; b_ready = 1'b0;
    do_read(4'd2, lat, rs);
    check_r("hazard_new");
    finish_read();
  endtask

  task automatic test_reset_mid();
    int lat; bit rs;
    do_read(4'd3, lat, rs);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1 || r_data !== '0) begin
      fails++;
      $display("FAIL reset_mid_r: rv=%b ar_ready=%b rd=%h want 0/1/0",
               r_valid, ar_ready, r_data);
    end
    void'(r_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    do_write(4'd9, 32'h9999_0009, 0, lat);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (b_valid !== 1'b0 || aw_ready !== 1'b1 || w_ready !== 1'b1 ||
        b_resp !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_b: bv=%b aw=%b w=%b br=%b want 0/1/1/0",
               b_valid, aw_ready, w_ready, b_resp);
    end
    void'(b_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    do_read(4'd3, lat, rs);
    check_r("survive_3");
    finish_read();
    do_read(4'd9, lat, rs);
    check_r("survive_9");
    finish_read();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_read_stall();
    test_write_w_first();
    test_errors();
    test_hazard();
    test_reset_mid();
    tests++;
    if (r_q.size() != 0 || b_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: r=%0d b=%0d left want 0/0",
               r_q.size(), b_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
